// File: rtl/seg7_scan_driver.sv
// Time-multiplexed DIGITS-wide 7-segment driver: shadow latch, prescaled digit scan,
// hex/BCD decode, leading-zero blanking and per-pin polarity on registered outputs.
module seg7_scan_driver #(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 50000,
  parameter bit SEG_ACT_LO = 1'b1,
  parameter bit AN_ACT_LO  = 1'b1,
  parameter bit HEX_MODE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  // XOR masks double as the inactive (all-off) pin levels
  localparam logic [6:0]        SEG_INV  = {7{SEG_ACT_LO}};
  localparam logic              DP_INV   = SEG_ACT_LO;
  localparam logic [DIGITS-1:0] AN_INV   = {DIGITS{AN_ACT_LO}};

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1111110;
      4'h1:    pat = 7'b0110000;
      4'h2:    pat = 7'b1101101;
      4'h3:    pat = 7'b1111001;
      4'h4:    pat = 7'b0110011;
      4'h5:    pat = 7'b1011011;
      4'h6:    pat = 7'b1011111;
      4'h7:    pat = 7'b1110000;
      4'h8:    pat = 7'b1111111;
      4'h9:    pat = 7'b1111011;
      4'hA:    pat = 7'b1110111;
      4'hB:    pat = 7'b0011111;
      4'hC:    pat = 7'b1001110;
      4'hD:    pat = 7'b0111101;
      4'hE:    pat = 7'b1001111;
      4'hF:    pat = 7'b1000111;
      default: pat = 7'b0000000;
    endcase
    if (!HEX_MODE && (nib > 4'd9)) begin
      pat = 7'b0000000;
    end else begin
      pat = pat;
    end
    return pat;
  endfunction

  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   sdp_q, sdp_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                fd_q, fd_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                tick_s;
  logic [3:0]          nib_s;
  logic                dpbit_s;
  logic [DIGITS-1:0]   an_oh_s;
  logic                upper_nz_s;
  logic                blank_s;
  logic [6:0]          seg_act_s;

  // Shadow capture and scan timing (prescaler, digit index, frame pulse)
  always_comb begin
    value_d = value_q;
    sdp_d   = sdp_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    fd_d    = 1'b0;
    tick_s  = en && (cnt_q == CNT_LAST);
    if (load) begin
      value_d = value_in;
      sdp_d   = dp_in;
    end else begin
      value_d = value_q;
      sdp_d   = sdp_q;
    end
    if (!en) begin
      cnt_d = cnt_q;
      idx_d = idx_q;
    end else if (tick_s) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      fd_d  = (idx_q == IDX_LAST);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Select the active digit and decide whether it sits in the leading-zero run
  always_comb begin
    nib_s      = 4'h0;
    dpbit_s    = 1'b0;
    an_oh_s    = '0;
    upper_nz_s = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (IDX_W'(k) == idx_q) begin
        nib_s      = value_q[4*k +: 4];
        dpbit_s    = sdp_q[k];
        an_oh_s[k] = 1'b1;
      end else begin
        an_oh_s[k] = 1'b0;
      end
      if ((IDX_W'(k) >= idx_q) && (value_q[4*k +: 4] != 4'h0)) begin
        upper_nz_s = 1'b1;
      end else begin
        upper_nz_s = upper_nz_s;
      end
    end
    blank_s   = blank_lz && (idx_q != '0) && !upper_nz_s;
    seg_act_s = blank_s ? 7'b0000000 : decode(nib_s);
  end

  // Pin values for the next edge; polarity applied here so pins come straight from flops
  always_comb begin
    seg_d = SEG_INV;
    dp_d  = DP_INV;
    an_d  = AN_INV;
    if (en) begin
      seg_d = seg_act_s ^ SEG_INV;
      dp_d  = dpbit_s ^ DP_INV;
      an_d  = an_oh_s ^ AN_INV;
    end else begin
      seg_d = SEG_INV;
      dp_d  = DP_INV;
      an_d  = AN_INV;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      sdp_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      fd_q    <= 1'b0;
      seg_q   <= SEG_INV;
      dp_q    <= DP_INV;
      an_q    <= AN_INV;
    end else begin
      value_q <= value_d;
      sdp_q   <= sdp_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      fd_q    <= fd_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule
